// File: rtl/uart_tx_fifo.sv
// FIFO-fed UART transmitter: start, 8 data bits LSB-first, stop; 16 br_tick pulses per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_TICKS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       br_tick,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_full,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    state_t        state;
    state_t        state_next;
    logic [4:0]    tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          tick_last;
    logic          stop_last;
    logic          tx_next;
    logic          done_next;
`ifdef UART_TX_PARITY_EN
    logic          par;
`endif

    // A push against a full FIFO is dropped even when the serialiser pops that cycle.
    assign tx_full   = (count == CW'(FIFO_DEPTH));
    assign push      = tx_start && !tx_full;
    assign pop       = (state == IDLE) && (count != '0);
    assign tick_last = br_tick && (tick_cnt == 5'd15);
    assign stop_last = br_tick && (tick_cnt == 5'(STOP_TICKS - 1));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (count != '0) state_next = START;
            START: if (tick_last) state_next = DATA;
            DATA:  if (tick_last && (bit_cnt == 3'd7))
`ifdef UART_TX_PARITY_EN
                       state_next = PARITY;
            PARITY: if (tick_last) state_next = STOP;
`else
                       state_next = STOP;
`endif
            STOP:  if (stop_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // tx is registered, so it is driven from the state and shift contents being entered.
    always_comb begin
        tx_busy   = (state != IDLE);
        done_next = (state == STOP) && stop_last;
        tx_next   = 1'b1;
        case (state_next)
            START:  tx_next = 1'b0;
            DATA:   tx_next = ((state == DATA) && tick_last) ? shreg[1] : shreg[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_next = par;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (pop) begin
                    shreg    <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                    par      <= ^mem[rd_ptr];
`endif
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                end
                DATA: if (br_tick) begin
                    if (tick_last) begin
                        tick_cnt <= '0;
                        shreg    <= shreg >> 1;
                        bit_cnt  <= bit_cnt + 3'd1;
                    end else begin
                        tick_cnt <= tick_cnt + 5'd1;
                    end
                end
                STOP: if (br_tick) begin
                    tick_cnt <= stop_last ? 5'd0 : tick_cnt + 5'd1;
                end
                default: if (br_tick) begin
                    tick_cnt <= tick_last ? 5'd0 : tick_cnt + 5'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            tx      <= tx_next;
            tx_done <= done_next;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level reference model checked every cycle, a mid-bit line
// decoder, and directed scenarios with literal expectations. Honours UART_TX_PARITY_EN.
module tb_uart_tx_fifo;
    localparam int DEPTH = 4;
    localparam int STOPT = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_TICKS = 144 + 16 * PAR + STOPT;
    localparam int LASTK = 9 + PAR;

    logic       clk;
    logic       rst_n;
    logic       br_tick;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_full;
    logic       tx_busy;
    logic       tx_done;
    logic       tx;

    uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .STOP_TICKS(STOPT)) dut (
        .clk(clk), .rst_n(rst_n), .br_tick(br_tick), .tx_start(tx_start), .tx_data(tx_data),
        .tx_full(tx_full), .tx_busy(tx_busy), .tx_done(tx_done), .tx(tx)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int tdiv = 0;

    // reference model state
    logic [7:0] mq[$];
    bit         in_frame = 0;
    int         ticks = 0;
    logic [7:0] cur = 8'h00;
    bit         push_ok;
    logic       m_tx = 1'b1;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic       m_full = 1'b0;
    bit         armed = 0;

    // line decoder state
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    logic [10:0] rx_bits = '0;
    logic        rx_prev = 1'b1;
    bit          rx_abort;
    logic [3:0]  rx_k;
    int          fall_times[$];
    int          done_times[$];
    int          done_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        br_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tdiv = (tdiv + 1) % 4;
            br_tick = (tdiv == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: actual %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic chk_range(input string name, input int val, input int lo, input int hi);
        n_chk++;
        if (val >= lo && val <= hi) n_pass++;
        else $display("FAIL %s: actual %0d expected %0d..%0d", name, val, lo, hi);
    endtask

    // Expected line level a given number of ticks into a frame carrying byte b.
    function automatic logic lvl(input logic [7:0] b, input int t);
        logic [7:0] s;
        if (t < 16) return 1'b0;
        if (t < 144) begin
            s = b >> ((t - 16) / 16);
            return s[0];
        end
        if (PAR == 1 && t < 160) return ^b;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            in_frame = 0;
            ticks = 0;
            m_tx = 1'b1;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_full = 1'b0;
            armed = 1;
        end else if (armed) begin
            push_ok = tx_start && (mq.size() < DEPTH);
            m_done = 1'b0;
            if (in_frame) begin
                if (br_tick) begin
                    ticks++;
                    if (ticks == FRAME_TICKS) begin
                        in_frame = 0;
                        m_done = 1'b1;
                    end
                end
            end else if (mq.size() != 0) begin
                cur = mq.pop_front();
                in_frame = 1;
                ticks = 0;
            end
            if (push_ok) mq.push_back(tx_data);
            m_full = (mq.size() == DEPTH);
            m_busy = in_frame;
            m_tx = in_frame ? lvl(cur, ticks) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("tx", tx, m_tx);
            chk("busy", tx_busy, m_busy);
            chk("done", tx_done, m_done);
            chk("full", tx_full, m_full);
            if (tx_done) begin
                done_cnt++;
                done_times.push_back(cyc);
            end
        end
    end

    // Decoder: samples each bit 32 clocks into its 64-clock slot (br_tick every 4 clocks).
    initial begin
        forever begin
            @(negedge clk);
            if (armed && rst_n && rx_prev && !tx) begin
                fall_times.push_back(cyc);
                rx_abort = 0;
                for (int n = 1; n <= 32 + 64 * LASTK; n++) begin
                    @(negedge clk);
                    if (!rst_n) rx_abort = 1;
                    if (n >= 32 && (n - 32) % 64 == 0) begin
                        rx_k = 4'((n - 32) / 64);
                        rx_bits[rx_k] = tx;
                    end
                end
                if (!rx_abort) rx_q.push_back(rx_bits[8:1]);
            end
            rx_prev = tx | !rst_n;
        end
    end

    task automatic push(input logic [7:0] d);
        tx_start = 1'b1;
        tx_data = d;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
    endtask

    task automatic wait_quiet(input string name, input int maxc);
        int n = 0;
        bit ok = 0;
        while (n < maxc && !ok) begin
            @(negedge clk);
            n++;
            if (!tx_busy && !in_frame && mq.size() == 0) ok = 1;
        end
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: still busy after %0d cycles", name, maxc);
        @(posedge clk);
        #1;
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    endtask

    task automatic clear_log();
        rx_q.delete();
        exp_q.delete();
        fall_times.delete();
        done_times.delete();
    endtask

    logic seq_a5 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int   d0;
    int   w;

    initial begin
        rst_n = 1'b0;
        tx_start = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        chk("rst_full", tx_full, 1'b0);
        @(posedge clk);
        #1;

        // single frame 0xA5
        clear_log();
        d0 = done_cnt;
        push(8'hA5);
        wait_quiet("t1_quiet", 2000);
        exp_q = '{8'hA5};
        check_rx("t1");
        for (int k = 0; k < 9; k++) chk($sformatf("t1_bit%0d", k), rx_bits[k], seq_a5[k]);
        chk("t1_stop", rx_bits[LASTK], seq_a5[9]);
        chk("t1_ndone", done_cnt - d0, 1);
        if (done_times.size() > 0 && fall_times.size() > 0)
            chk_range("t1_len", done_times[0] - fall_times[0],
                      4 * (FRAME_TICKS - 1) + 1, 4 * (FRAME_TICKS - 1) + 4);
        else chk("t1_len_seen", 0, 1);

        // back-to-back frames
        clear_log();
        d0 = done_cnt;
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        wait_quiet("t2_quiet", 3000);
        exp_q = '{8'h00, 8'hFF, 8'h3C};
        check_rx("t2");
        chk("t2_ndone", done_cnt - d0, 3);
        if (done_times.size() == 3 && fall_times.size() == 3) begin
            chk("t2_gap1", fall_times[1] - done_times[0], 1);
            chk("t2_gap2", fall_times[2] - done_times[1], 1);
        end else chk("t2_edges", done_times.size() * 16 + fall_times.size(), 3 * 16 + 3);

        // overflow while busy
        clear_log();
        push(8'h0F);
        repeat (3) begin @(posedge clk); #1; end
        push(8'h10);
        push(8'h11);
        push(8'h12);
        @(negedge clk); chk("t3_full_after3", tx_full, 1'b0);
        @(posedge clk); #1;
        push(8'h13);
        @(negedge clk); chk("t3_full_after4", tx_full, 1'b1);
        @(posedge clk); #1;
        push(8'h14);
        @(negedge clk); chk("t3_full_after5", tx_full, 1'b1);
        @(posedge clk); #1;
        wait_quiet("t3_quiet", 5000);
        exp_q = '{8'h0F, 8'h10, 8'h11, 8'h12, 8'h13};
        check_rx("t3");

        // push against full in the same cycle as the IDLE pop
        clear_log();
        push(8'h20);
        repeat (3) begin @(posedge clk); #1; end
        push(8'h21);
        push(8'h22);
        push(8'h23);
        push(8'h24);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!tx_done && w < 1000);
        chk("t4_done_seen", tx_done, 1'b1);
        chk("t4_full_before", tx_full, 1'b1);
        tx_start = 1'b1;
        tx_data = 8'h99;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        @(negedge clk); chk("t4_full_after", tx_full, 1'b0);
        @(posedge clk); #1;
        wait_quiet("t4_quiet", 5000);
        exp_q = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
        check_rx("t4");

        // reset mid-frame during data bit 3 of 0x55
        clear_log();
        d0 = done_cnt;
        push(8'h55);
        repeat (3) begin @(posedge clk); #1; end
        push(8'h66);
        push(8'h77);
        repeat (285) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("t5_bit3", tx, 1'b0);
        chk("t5_busy_pre", tx_busy, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t5_tx", tx, 1'b1);
        chk("t5_busy", tx_busy, 1'b0);
        chk("t5_full", tx_full, 1'b0);
        chk("t5_done", tx_done, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        d0 = done_cnt;
        fall_times.delete();
        repeat (800) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("t5_ndone", done_cnt - d0, 0);
        chk("t5_nframes", fall_times.size(), 0);
        chk("t5_nbytes", rx_q.size(), 0);
        chk("t5_tx_idle", tx, 1'b1);
        @(posedge clk);
        #1;

`ifdef UART_TX_PARITY_EN
        clear_log();
        push(8'h07);
        wait_quiet("t6_quiet_a", 2000);
        exp_q = '{8'h07};
        check_rx("t6a");
        chk("t6_par07", rx_bits[9], 1'b1);
        chk("t6_stop07", rx_bits[10], 1'b1);
        if (done_times.size() > 0 && fall_times.size() > 0)
            chk_range("t6_len", done_times[0] - fall_times[0], 4 * 175 + 1, 4 * 175 + 4);
        else chk("t6_len_seen", 0, 1);
        clear_log();
        push(8'h03);
        wait_quiet("t6_quiet_b", 2000);
        exp_q = '{8'h03};
        check_rx("t6b");
        chk("t6_par03", rx_bits[9], 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

UART transmitter for the Basys front-end serial link, the transmit-side counterpart of the 16x-oversampled UART receiver. It accepts bytes from on-chip logic through a small FIFO and serialises each byte on `tx` as start bit, 8 data bits LSB-first, optional parity and stop, one bit per 16 `br_tick` pulses. It shares the baud-tick generator with the receiver.

## Interface
- `FIFO_DEPTH`, 4: transmit FIFO entries; power of two, at least 2.
- `STOP_TICKS`, 16: `br_tick` pulses in the stop bit; range 16..32.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `br_tick`  in  1  single-cycle pulse at 16x baud, from the shared baud generator.
- `tx_start`  in  1  push strobe; `tx_data` is written when `tx_start && !tx_full`.
- `tx_data`  in  8  byte to transmit.
- `tx_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `tx_busy`  out  1  high whenever the serialiser state is not IDLE.
- `tx_done`  out  1  one-cycle pulse at the end of each frame's stop bit.
- `tx`  out  1  serial line; registered; idle-high.

## Operation
- Reset values (`rst_n` low at a clock edge):
  - `tx` = 1; `tx_busy` = 0; `tx_done` = 0; `tx_full` = 0.
  - FIFO emptied; state is IDLE; tick, bit and shift registers are 0.
- FIFO:
  - Circular buffer with read and write pointers and a count of width log2(FIFO_DEPTH)+1; pointers wrap modulo `FIFO_DEPTH`.
  - A push while `tx_full` (registered) is silently dropped, even if a pop occurs in the same cycle.
  - A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE:
  - `tx` = 1.
  - If the FIFO is non-empty: pop the head into the shift register, clear the tick and bit counters, go to START.
- START:
  - `tx` = 0.
  - Tick counter increments on `br_tick`.
  - On the 16th tick (count 15): clear the counter, go to DATA.
- DATA:
  - `tx` = shift register bit 0.
  - On each 16th tick: shift right and increment the bit count.
  - After bit 7: go to PARITY if enabled, otherwise STOP.
- STOP:
  - `tx` = 1.
  - On the tick where count = `STOP_TICKS`-1: go to IDLE, pulse `tx_done` for 1 cycle, clear the counter.
- `tx_busy` is derived combinationally from state != IDLE.
- `br_tick` pulses outside START/DATA/PARITY/STOP are ignored.

## Timing
- Push at edge N: FIFO is non-empty after edge N.
- Edge N+1: IDLE pops the entry, state becomes START, `tx` drives 0 from the N+1 registered update. Push-to-start-bit latency is 2 clocks from the `tx_start` cycle.
- The frame is timed by `br_tick` only: 16 + 128 (+16 parity) + `STOP_TICKS` ticks. With defaults and no parity this is 160 ticks.
- Back-to-back frames: the cycle after `tx_done`, IDLE pops the next entry if one is present. The gap is exactly 1 clock of idle-high.
- `tx_done` coincides with the STOP→IDLE clock edge; `tx_busy` falls on that same edge.
- A reset asserted mid-frame aborts on that edge: `tx` returns high at once and queued bytes are discarded.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state inserted after DATA, lasting 16 ticks.
  - `tx` = even parity (XOR of the 8 data bits), computed at pop time and held in a register.
- Not defined: no PARITY state; DATA goes directly to STOP; frame length as above without the +16.

## Test plan
- Reset, `br_tick` every 4 clocks, push 0xA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each level held 64 clocks; one `tx_done` pulse; `tx_busy` high throughout the frame.
- Push 0x00, 0xFF, 0x3C on consecutive cycles → three frames, each separated by exactly 1 idle clock; three `tx_done` pulses; no byte lost.
- With the serialiser busy, push `FIFO_DEPTH`+1 bytes (0x10..0x14) → `tx_full` rises after the 4th push; 0x14 dropped; only 0x10..0x13 transmitted, in order.
- At full, assert push in the same cycle as the IDLE pop → the byte is dropped; count becomes `FIFO_DEPTH`-1.
- Drop `rst_n` during DATA bit 3 of 0x55 with 2 bytes queued → next clock `tx`=1, `tx_busy`=0, `tx_full`=0; no further frames and no `tx_done`.
- With `UART_TX_PARITY_EN`, push 0x07 → parity bit 1 between data and stop; frame 176 ticks. Push 0x03 → parity bit 0.
